// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: reads a 16-bit word count, assembles
// little-endian 32-bit words from a byte stream and writes them to the RAM.
module imem_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic              byte_valid_in,
    input  logic [7:0]        byte_in,
    output logic              byte_ready_out,
    output logic              we_out,
    output logic [ADDR_W-1:0] address_out,
    output logic [DATA_W-1:0] data_out,
    output logic              core_rst_n_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              error_out
);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, COLLECT, WRITE, DONE, ERROR
    } state_t;

    localparam logic [16:0] MAX_COUNT = 17'(1) << ADDR_W;

    state_t      state, state_next;
    logic [15:0] remaining;
    logic [1:0]  byte_idx;
    logic        accept;
    logic        len_bad;

    assign accept  = byte_valid_in && byte_ready_out;
    assign len_bad = ({byte_in, remaining[7:0]} == 16'd0)
                  || ({1'b0, byte_in, remaining[7:0]} > MAX_COUNT);

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERROR: if (start_in) state_next = LEN_LO;
            LEN_LO:  if (accept) state_next = LEN_HI;
            LEN_HI:  if (accept) state_next = len_bad ? ERROR : COLLECT;
            COLLECT: if (accept && byte_idx == 2'd3) state_next = WRITE;
            WRITE:   state_next = (remaining == 16'd1) ? DONE : COLLECT;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            remaining      <= '0;
            byte_idx       <= '0;
            address_out    <= '0;
            data_out       <= '0;
            byte_ready_out <= 1'b0;
            we_out         <= 1'b0;
            core_rst_n_out <= 1'b0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
            error_out      <= 1'b0;
        end else begin
            state          <= state_next;
            byte_ready_out <= (state_next == LEN_LO) || (state_next == LEN_HI)
                           || (state_next == COLLECT);
            we_out         <= (state_next == WRITE);
            busy_out       <= (state_next == LEN_LO) || (state_next == LEN_HI)
                           || (state_next == COLLECT) || (state_next == WRITE);
            done_out       <= (state_next == DONE);
            error_out      <= (state_next == ERROR);
            core_rst_n_out <= (state_next == DONE);

            case (state)
                IDLE, DONE, ERROR: begin
                    if (start_in) begin
                        address_out <= '0;
                        byte_idx    <= '0;
                    end
                end
                LEN_LO:  if (accept) remaining[7:0]  <= byte_in;
                LEN_HI:  if (accept) remaining[15:8] <= byte_in;
                COLLECT: begin
                    if (accept) begin
                        // Shifting in from the top leaves byte 0 in [7:0] after four bytes.
                        data_out <= {byte_in, data_out[DATA_W-1:8]};
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    address_out <= address_out + 1'b1;
                    remaining   <= remaining - 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
